branch_predictor: RTL and testbench

Dynamic branch-prediction responder for the 32-bit RISC-V core. The fetch stage issues lookups by PC. This block answers each lookup one cycle later with a taken/not-taken prediction and a target, read from a direct-mapped BTB with 2-bit saturating counters. The execute stage returns resolved outcomes through an update port, and the block trains its tables from them.

---
 rtl/branch_predictor_pkg.sv | 29 ++
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor_sat_counter.sv | 19 +
 rtl/branch_predictor.sv | 135 +++++++++++++
 tb/tb_branch_predictor.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: FSM states, 2-bit
// counter encodings and table field-width helpers.
package bpred_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [1:0] CTR_RST   = WNT;
  localparam logic [1:0] CTR_ALLOC = WT;

  function automatic int calc_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // PC layout is {tag, index, 2'b00}
  function automatic int calc_tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup / execute update bundle between the core and the branch predictor.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            ready;
  logic            lookup_valid;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            update_mispredict;
  logic [31:0]     mispredict_cnt;

  modport master (
    output lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
           update_target, update_mispredict,
    input  ready, pred_valid, pred_taken, pred_target, mispredict_cnt
  );

  modport slave (
    input  lookup_valid, lookup_pc, update_valid, update_pc, update_taken,
           update_target, update_mispredict,
    output ready, pred_valid, pred_taken, pred_target, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state logic for a 2-bit saturating branch counter.
module bpred_sat_counter
  import bpred_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
    end else if (i_ctr != SNT) begin
      o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter branch predictor with one-cycle lookup.
// Optional gshare indexing is enabled by defining BPRED_GSHARE_EN.
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input logic              clk,
  input logic              rst,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = calc_idx_w(ENTRIES);
  localparam int TAG_W = calc_tag_w(XLEN, ENTRIES);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_sweep;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [XLEN-1:0]  r_pred_target;
  logic [31:0]      r_mis_cnt;

  logic             w_run;
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_lk_hit;
  logic             w_lk_taken;
  logic             w_up_hit;
  logic [1:0]       w_ctr_nxt;
  logic             w_unused_pc;

  assign w_run       = (r_state == RUN);
  assign w_lk_tag    = bp.lookup_pc[XLEN-1:IDX_W+2];
  assign w_up_tag    = bp.update_pc[XLEN-1:IDX_W+2];
  assign w_unused_pc = ^{bp.lookup_pc[1:0], bp.update_pc[1:0]};

`ifdef BPRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  assign w_lk_idx = bp.lookup_pc[IDX_W+1:2] ^ r_ghr;
  assign w_up_idx = bp.update_pc[IDX_W+1:2] ^ r_ghr;

  always_ff @(posedge clk) begin
    if (rst || !w_run) r_ghr <= '0;
    else if (bp.update_valid) r_ghr <= {r_ghr[IDX_W-2:0], bp.update_taken};
  end
`else
  assign w_lk_idx = bp.lookup_pc[IDX_W+1:2];
  assign w_up_idx = bp.update_pc[IDX_W+1:2];
`endif

  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_run && w_lk_hit && r_ctr[w_lk_idx][1];
  assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  bpred_sat_counter u_sat (
    .i_ctr   (r_ctr[w_up_idx]),
    .i_taken (bp.update_taken),
    .o_ctr   (w_ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT: if (r_sweep == IDX_W'(ENTRIES - 1)) w_state_nxt = RUN;
      RUN:  w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         r_sweep <= '0;
    else if (!w_run) r_sweep <= r_sweep + 1'b1;
  end

  // Table writes: sweep clear during INIT, training during RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) begin
        r_valid[r_sweep] <= 1'b0;
        r_ctr[r_sweep]   <= CTR_RST;
      end else if (bp.update_valid) begin
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= w_ctr_nxt;
          if (bp.update_taken) r_target[w_up_idx] <= bp.update_target;
        end else if (bp.update_taken) begin
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= bp.update_target;
          r_ctr[w_up_idx]    <= CTR_ALLOC;
        end
      end
    end
  end

  // Registered response: reads the pre-update entry on a same-cycle update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_pred_valid  <= bp.lookup_valid;
      r_pred_taken  <= bp.lookup_valid && w_lk_taken;
      r_pred_target <= (bp.lookup_valid && w_lk_taken) ? r_target[w_lk_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_mis_cnt <= '0;
    else if (bp.update_valid && bp.update_mispredict) r_mis_cnt <= r_mis_cnt + 32'd1;
  end

  assign bp.ready          = w_run;
  assign bp.pred_valid     = r_pred_valid;
  assign bp.pred_taken     = r_pred_taken;
  assign bp.pred_target    = r_pred_target;
  assign bp.mispredict_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default PC-indexed build, ENTRIES=64).
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n;
  logic lk_v, lk_t;
  logic [31:0] lk_tgt;

  branch_predictor_if #(.XLEN(32)) bp_if ();

  branch_predictor #(.ENTRIES(64), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bp_if.lookup_valid      = 1'b0;
    bp_if.lookup_pc         = '0;
    bp_if.update_valid      = 1'b0;
    bp_if.update_pc         = '0;
    bp_if.update_taken      = 1'b0;
    bp_if.update_target     = '0;
    bp_if.update_mispredict = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic mis);
    bp_if.update_valid      = 1'b1;
    bp_if.update_pc         = pc;
    bp_if.update_taken      = taken;
    bp_if.update_target     = tgt;
    bp_if.update_mispredict = mis;
    step();
    bp_if.update_valid      = 1'b0;
    bp_if.update_mispredict = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc, output logic v, output logic t,
                           output logic [31:0] tgt);
    bp_if.lookup_valid = 1'b1;
    bp_if.lookup_pc    = pc;
    step();
    v   = bp_if.pred_valid;
    t   = bp_if.pred_taken;
    tgt = bp_if.pred_target;
    bp_if.lookup_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bp_if.ready && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    idle_inputs();
    repeat (3) step();
    chk("rst_ready", bp_if.ready, 0);
    chk("rst_pvalid", bp_if.pred_valid, 0);
    chk("rst_ptaken", bp_if.pred_taken, 0);
    chk("rst_ptarget", bp_if.pred_target, 0);
    chk("rst_miscnt", bp_if.mispredict_cnt, 0);

    // Release reset with a lookup pending, and an update landing during INIT
    rst = 1'b0;
    bp_if.lookup_valid = 1'b1;
    bp_if.lookup_pc    = 32'h0000_0040;
    n = 0;
    while (!bp_if.ready && n < 200) begin
      step();
      n++;
      if (n == 1) begin
        chk("init_lk_valid", bp_if.pred_valid, 1);
        chk("init_lk_taken", bp_if.pred_taken, 0);
        bp_if.lookup_valid      = 1'b0;
        bp_if.update_valid      = 1'b1;
        bp_if.update_pc         = 32'h100;
        bp_if.update_taken      = 1'b1;
        bp_if.update_target     = 32'h200;
        bp_if.update_mispredict = 1'b1;
      end else if (n == 2) begin
        idle_inputs();
      end
    end
    chk("ready_latency", n, 64);
    chk("init_miscnt", bp_if.mispredict_cnt, 1);
    do_lookup(32'h100, lk_v, lk_t, lk_tgt);
    chk("init_upd_dropped", lk_t, 0);

    // Allocation
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    do_lookup(32'h100, lk_v, lk_t, lk_tgt);
    chk("alloc_taken", lk_t, 1);
    chk("alloc_target", lk_tgt, 32'h200);

    // Saturate up (10 -> 11), target follows latest taken update
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    do_update(32'h100, 1'b1, 32'h200, 1'b0);
    do_update(32'h100, 1'b1, 32'h240, 1'b0);
    do_lookup(32'h100, lk_v, lk_t, lk_tgt);
    chk("sat_hi_target", lk_tgt, 32'h240);
    do_update(32'h100, 1'b0, 32'h0, 1'b0);
    do_lookup(32'h100, lk_v, lk_t, lk_tgt);
    chk("dec_to_wt_taken", lk_t, 1);
    chk("dec_keeps_target", lk_tgt, 32'h240);
    do_update(32'h100, 1'b0, 32'h0, 1'b0);
    do_lookup(32'h100, lk_v, lk_t, lk_tgt);
    chk("dec_to_wnt_taken", lk_t, 0);
    chk("dec_to_wnt_target", lk_tgt, 0);

    // Saturate down at 00, then climb back: 01 predicts not taken, 10 taken
    repeat (3) do_update(32'h100, 1'b0, 32'h0, 1'b0);
    do_update(32'h100, 1'b1, 32'h240, 1'b0);
    do_lookup(32'h100, lk_v, lk_t, lk_tgt);
    chk("sat_lo_then_01", lk_t, 0);
    do_update(32'h100, 1'b1, 32'h240, 1'b0);
    do_lookup(32'h100, lk_v, lk_t, lk_tgt);
    chk("sat_lo_then_10", lk_t, 1);

    // Aliasing: 0x1100 shares index 0 with 0x100
    do_update(32'h1100, 1'b1, 32'h500, 1'b0);
    do_lookup(32'h100, lk_v, lk_t, lk_tgt);
    chk("alias_old_miss", lk_t, 0);
    do_lookup(32'h1100, lk_v, lk_t, lk_tgt);
    chk("alias_new_taken", lk_t, 1);
    chk("alias_new_target", lk_tgt, 32'h500);
    do_update(32'h100, 1'b0, 32'h0, 1'b0);
    do_lookup(32'h1100, lk_v, lk_t, lk_tgt);
    chk("miss_nt_nochange", lk_t, 1);

    // Back-to-back lookups
    bp_if.lookup_valid = 1'b1;
    bp_if.lookup_pc    = 32'h1100;
    step();
    chk("b2b_0_taken", bp_if.pred_taken, 1);
    chk("b2b_0_target", bp_if.pred_target, 32'h500);
    bp_if.lookup_pc = 32'h104;
    step();
    chk("b2b_1_valid", bp_if.pred_valid, 1);
    chk("b2b_1_taken", bp_if.pred_taken, 0);
    bp_if.lookup_valid = 1'b0;
    step();
    chk("b2b_idle_valid", bp_if.pred_valid, 0);

    // Same-cycle allocate and lookup of 0x300 (also index 0)
    bp_if.lookup_valid  = 1'b1;
    bp_if.lookup_pc     = 32'h300;
    bp_if.update_valid  = 1'b1;
    bp_if.update_pc     = 32'h300;
    bp_if.update_taken  = 1'b1;
    bp_if.update_target = 32'h340;
    step();
    idle_inputs();
    chk("rbw_valid", bp_if.pred_valid, 1);
    chk("rbw_miss", bp_if.pred_taken, 0);
    do_lookup(32'h300, lk_v, lk_t, lk_tgt);
    chk("rbw_next_taken", lk_t, 1);
    chk("rbw_next_target", lk_tgt, 32'h340);
    do_lookup(32'h1100, lk_v, lk_t, lk_tgt);
    chk("replaced_miss", lk_t, 0);

    // Reset mid-operation with a lookup in flight
    bp_if.lookup_valid = 1'b1;
    bp_if.lookup_pc    = 32'h300;
    rst = 1'b1;
    step();
    chk("mid_rst_ready", bp_if.ready, 0);
    chk("mid_rst_pvalid", bp_if.pred_valid, 0);
    idle_inputs();
    rst = 1'b0;
    wait_ready(n);
    chk("ready_latency2", n, 64);
    do_lookup(32'h300, lk_v, lk_t, lk_tgt);
    chk("post_rst_miss", lk_t, 0);

    // Mispredict counting: a mispredict flag without update_valid is ignored
    bp_if.update_mispredict = 1'b1;
    step();
    bp_if.update_mispredict = 1'b0;
    chk("mis_needs_valid", bp_if.mispredict_cnt, 0);
    repeat (5) do_update(32'h700, 1'b0, 32'h0, 1'b1);
    chk("mis_cnt5", bp_if.mispredict_cnt, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
